spi_led_ctrl: RTL and testbench

//  Command sequencer behind the SPI slave. Consumes decoded frames (cmd/addr/payload + valid strobe),

---
 rtl/spi_led_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_spi_led_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: command sequencer behind the SPI slave.
//   Consumes decoded frames (cmd/addr/payload + valid strobe). Keeps a per-LED brightness register
//   file (0..100 %). Drives one PWM output per LED. Returns read-back brightness over valid/ready.
// Optional feature: define LED_FADE_EN to make each displayed level slew toward its target by one
//   step every FADE_DIV cycles. Left undefined, the level tracks the target immediately.
// Command and field widths normally come from params.vh. Local defaults are used if not defined.
// Ports:
//   sysclk         system clock
//   rst            asynchronous reset, active-high
//   i_frame_valid  one-cycle pulse, frame fields valid
//   i_cmd          command byte (NOP/WRITE/READ)
//   i_addr         LED index
//   i_payload      brightness in percent for WRITE
//   o_tx_data      read-back brightness, held while o_tx_valid
//   o_tx_valid     read-back valid, held until i_tx_ready
//   i_tx_ready     transmit side accepts o_tx_data
//   o_led          PWM outputs, bit i drives LED i
//   o_err          one-cycle pulse on bad command, bad address or dropped frame

`ifndef CMD_BITS
  `define CMD_BITS 8
`endif
`ifndef ADDR_BITS
  `define ADDR_BITS 8
`endif
`ifndef PAYLOAD_BITS
  `define PAYLOAD_BITS 8
`endif
`ifndef CMD_NOP
  `define CMD_NOP 8'h00
`endif
`ifndef CMD_WRITE
  `define CMD_WRITE 8'h01
`endif
`ifndef CMD_READ
  `define CMD_READ 8'h02
`endif

module spi_led_ctrl #(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned PWM_DIV  = 1250,
  parameter int unsigned FADE_DIV = 12500
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     i_frame_valid,
  input  logic [`CMD_BITS-1:0]     i_cmd,
  input  logic [`ADDR_BITS-1:0]    i_addr,
  input  logic [`PAYLOAD_BITS-1:0] i_payload,
  output logic [`PAYLOAD_BITS-1:0] o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [N_LEDS-1:0]        o_led,
  output logic                     o_err
);

  localparam int unsigned IdxW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int unsigned PdW  = $clog2((PWM_DIV > 1) ? PWM_DIV : 2);

  typedef enum logic [2:0] {StIdle, StDecode, StWrite, StRead, StResp, StErr} state_e;

  state_e r_state, w_state_next;

  logic [`CMD_BITS-1:0]     r_cmd;
  logic [`ADDR_BITS-1:0]    r_addr;
  logic [`PAYLOAD_BITS-1:0] r_payload;
  logic [`PAYLOAD_BITS-1:0] r_tx_data;
  logic                     r_tx_valid;
  logic                     r_err;
  logic [6:0]               r_target [N_LEDS];
  logic [6:0]               w_level  [N_LEDS];
  logic [PdW-1:0]           r_pwm_div;
  logic [6:0]               r_pwm_cnt;
  logic [N_LEDS-1:0]        r_led;

  logic            w_addr_bad;
  logic            w_cmd_known;
  logic            w_do_write;
  logic            w_do_read;
  logic            w_err_next;
  logic            w_accept;
  logic [IdxW-1:0] w_idx;
  logic [6:0]      w_clamped;

  assign w_idx       = r_addr[IdxW-1:0];
  assign w_addr_bad  = (32'(r_addr) >= N_LEDS);
  assign w_cmd_known = (r_cmd == `CMD_WRITE) || (r_cmd == `CMD_READ);
  assign w_clamped   = (r_payload > `PAYLOAD_BITS'(100)) ? 7'd100 : r_payload[6:0];
  assign w_accept    = r_tx_valid && i_tx_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_frame_valid) w_state_next = StDecode;
      StDecode: begin
        if (r_cmd == `CMD_NOP)             w_state_next = StIdle;
        else if (!w_cmd_known || w_addr_bad) w_state_next = StErr;
        else if (r_cmd == `CMD_WRITE)      w_state_next = StWrite;
        else                               w_state_next = StRead;
      end
      StWrite:  w_state_next = StIdle;
      // Response is already valid in StRead, so a ready-high sink completes in one cycle.
      StRead,
      StResp:   w_state_next = w_accept ? StIdle : StResp;
      StErr:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Register-file and response actions fire on the edge leaving StDecode; this gives the two-cycle
  // frame-to-visible latency.
  assign w_do_write = (r_state == StDecode) && (w_state_next == StWrite);
  assign w_do_read  = (r_state == StDecode) && (w_state_next == StRead);
  assign w_err_next = ((r_state == StDecode) && (w_state_next == StErr)) ||
                      (i_frame_valid && (r_state != StIdle));

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_payload  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if ((r_state == StIdle) && i_frame_valid) begin
        r_cmd     <= i_cmd;
        r_addr    <= i_addr;
        r_payload <= i_payload;
      end
      if (w_do_read) begin
        r_tx_data  <= `PAYLOAD_BITS'(w_level[w_idx]);
        r_tx_valid <= 1'b1;
      end else if (w_accept) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LEDS; i++) r_target[i] <= '0;
    end else if (w_do_write) begin
      r_target[w_idx] <= w_clamped;
    end
  end

`ifdef LED_FADE_EN
  localparam int unsigned FdW = $clog2((FADE_DIV > 1) ? FADE_DIV : 2);

  logic [FdW-1:0] r_fade_div;
  logic [6:0]     r_level [N_LEDS];
  logic           w_fade_tick;

  assign w_fade_tick = (r_fade_div == FdW'(FADE_DIV - 1));

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_fade_div <= '0;
      for (int i = 0; i < N_LEDS; i++) r_level[i] <= '0;
    end else begin
      r_fade_div <= w_fade_tick ? '0 : r_fade_div + 1'b1;
      if (w_fade_tick) begin
        for (int i = 0; i < N_LEDS; i++) begin
          if (r_level[i] < r_target[i])      r_level[i] <= r_level[i] + 7'd1;
          else if (r_level[i] > r_target[i]) r_level[i] <= r_level[i] - 7'd1;
        end
      end
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_target;
`endif

  // Shared PWM step counter 0..99, one step per PWM_DIV cycles.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_pwm_div <= '0;
      r_pwm_cnt <= '0;
    end else if (r_pwm_div == PdW'(PWM_DIV - 1)) begin
      r_pwm_div <= '0;
      r_pwm_cnt <= (r_pwm_cnt == 7'd99) ? 7'd0 : r_pwm_cnt + 7'd1;
    end else begin
      r_pwm_div <= r_pwm_div + 1'b1;
    end
  end

  // cnt < level: level 0 never lights, level 100 always lights since cnt tops out at 99.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) r_led[i] <= (r_pwm_cnt < w_level[i]);
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_led      = r_led;
  assign o_err      = r_err;

endmodule

// File: tb/tb_spi_led_ctrl.sv
// Testbench for spi_led_ctrl: directed scenarios plus a randomized frame stream. A reference model
// of the brightness table pushes expected read-back values into a queue; a negedge monitor pops
// them on each transmit handshake and counts error pulses.
module tb_spi_led_ctrl;

  localparam int unsigned NLeds   = 4;
  localparam int unsigned PwmDiv  = 3;
  localparam int unsigned FadeDiv = 5;
  localparam int unsigned Period  = 100 * PwmDiv;

  logic             sysclk = 1'b0;
  logic             rst;
  logic             i_frame_valid;
  logic [7:0]       i_cmd;
  logic [7:0]       i_addr;
  logic [7:0]       i_payload;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_ready;
  logic [NLeds-1:0] o_led;
  logic             o_err;

  spi_led_ctrl #(
    .N_LEDS  (NLeds),
    .PWM_DIV (PwmDiv),
    .FADE_DIV(FadeDiv)
  ) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .i_frame_valid(i_frame_valid),
    .i_cmd        (i_cmd),
    .i_addr       (i_addr),
    .i_payload    (i_payload),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_led        (o_led),
    .o_err        (o_err)
  );

  always #4 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;
  int err_exp  = 0;
  int err_seen = 0;
  int model_level [NLeds];
  int exp_q [$];
  int rdy_mode = 0;  // 0 low, 1 high, 2 random

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ready driver: the only process writing i_tx_ready.
  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      case (rdy_mode)
        0:       i_tx_ready = 1'b0;
        1:       i_tx_ready = 1'b1;
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted response and counts error pulses.
  initial begin
    forever begin
      @(negedge sysclk);
      if (!rst) begin
        if (o_err) err_seen++;
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) check("tx_unexpected", 0, 1);
          else check("tx_data", int'(o_tx_data), exp_q.pop_front());
        end
      end
    end
  end

  // Reference model applied at issue time; returns 1 when a response is expected.
  function automatic bit model_frame(input int cmd, input int addr, input int payload);
    model_frame = 1'b0;
    if (cmd == 0) return 1'b0;
    if ((cmd != 1 && cmd != 2) || addr >= NLeds) begin
      err_exp++;
      return 1'b0;
    end
    if (cmd == 1) begin
      model_level[addr] = (payload > 100) ? 100 : payload;
    end else begin
      exp_q.push_back(model_level[addr]);
      model_frame = 1'b1;
    end
  endfunction

  // Called just after a posedge; leaves just after a posedge.
  task automatic pulse_frame(input int cmd, input int addr, input int payload);
    i_frame_valid = 1'b1;
    i_cmd         = 8'(cmd);
    i_addr        = 8'(addr);
    i_payload     = 8'(payload);
    @(posedge sysclk);
    #1;
    i_frame_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge sysclk);
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  task automatic issue(input int cmd, input int addr, input int payload);
    bit rd;
    rd = model_frame(cmd, addr, payload);
    pulse_frame(cmd, addr, payload);
    if (rd) wait_empty("resp_timeout");
    else begin
      repeat (4) @(posedge sysclk);
      #1;
    end
  endtask

  // Counts high cycles per LED over one full PWM period and compares with level * PwmDiv.
  task automatic check_duty(input string name, input bit expect_dark);
    int cnt [NLeds];
    for (int i = 0; i < NLeds; i++) cnt[i] = 0;
    for (int c = 0; c < Period; c++) begin
      @(negedge sysclk);
      for (int i = 0; i < NLeds; i++) cnt[i] += int'(o_led[i]);
    end
    for (int i = 0; i < NLeds; i++)
      check($sformatf("%s_led%0d", name, i), cnt[i], expect_dark ? 0 : model_level[i] * PwmDiv);
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    i_frame_valid = 1'b0;
    i_cmd         = '0;
    i_addr        = '0;
    i_payload     = '0;
    for (int i = 0; i < NLeds; i++) model_level[i] = 0;

    repeat (3) @(negedge sysclk);
    check("rst_tx_valid", int'(o_tx_valid), 0);
    check("rst_tx_data", int'(o_tx_data), 0);
    check("rst_led", int'(o_led), 0);
    check("rst_err", int'(o_err), 0);
    @(posedge sysclk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;

    // Basic write and duty cycle; other LEDs stay dark.
    rdy_mode = 1;
    issue(1, 1, 25);
    check_duty("duty25", 1'b0);

    // Clamp: 200 becomes 100 and reads back as 100.
    issue(1, 2, 200);
    issue(2, 2, 0);
    check_duty("duty_clamp", 1'b0);

    // Back-pressure: response held stable while ready is low.
    rdy_mode = 0;
    repeat (2) @(posedge sysclk);
    #1;
    void'(model_frame(2, 0, 0));
    pulse_frame(2, 0, 0);
    repeat (2) @(posedge sysclk);
    for (int c = 0; c < 10; c++) begin
      @(negedge sysclk);
      check("hold_valid", int'(o_tx_valid), 1);
      check("hold_data", int'(o_tx_data), model_level[0]);
    end
    @(posedge sysclk);
    #1;
    rdy_mode = 1;
    wait_empty("hold_release");
    check("hold_dropped", int'(o_tx_valid), 0);

    // Errors: unknown command, bad address, frame dropped while in RESP.
    issue(8'h7F, 0, 10);
    issue(1, NLeds, 10);
    rdy_mode = 0;
    repeat (2) @(posedge sysclk);
    #1;
    void'(model_frame(2, 3, 0));
    pulse_frame(2, 3, 0);
    repeat (4) @(posedge sysclk);
    #1;
    err_exp++;
    pulse_frame(1, 0, 50);
    repeat (3) @(posedge sysclk);
    #1;
    rdy_mode = 1;
    wait_empty("err_resp");
    check("err_count_directed", err_seen, err_exp);
    check_duty("duty_after_err", 1'b0);

    // Randomized frame stream with random ready.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      int sel, cmd;
      sel = int'($urandom_range(0, 3));
      cmd = (sel == 3) ? int'($urandom_range(3, 255)) : sel;
      issue(cmd, int'($urandom_range(0, NLeds + 1)), int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NLeds; i++) issue(2, i, 0);
    rdy_mode = 1;
    check_duty("duty_random", 1'b0);

    // Reset mid-RESP: outputs clear at once, pending response discarded, LEDs stay dark.
    issue(1, 3, 100);
    rdy_mode = 0;
    repeat (2) @(posedge sysclk);
    #1;
    pulse_frame(2, 3, 0);
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("pre_rst_valid", int'(o_tx_valid), 1);
    @(posedge sysclk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(o_tx_valid), 0);
    check("mid_rst_data", int'(o_tx_data), 0);
    check("mid_rst_led", int'(o_led), 0);
    check("mid_rst_err", int'(o_err), 0);
    for (int i = 0; i < NLeds; i++) model_level[i] = 0;
    exp_q.delete();
    repeat (2) @(posedge sysclk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    check_duty("post_rst", 1'b1);
    issue(2, 3, 0);

    check("err_count_total", err_seen, err_exp);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
